hazard_unit_multi: RTL
======================

Name: hazard_unit_multi

Overview:
Parametrised successor to the pipeline's load-use hazard detector. Sits beside the ID stage of the 5-stage MIPS pipeline and drives the PC/IF-ID write enables, the ID/EX bubble mux and the IF/ID flush. It generalises detection to:
- configurable register-address width
- configurable load-use penalty (multi-cycle stall FSM)
- branch-in-ID hazards
- an external whole-pipeline freeze, e.g. a cache miss
- a saturating stall-cycle counter

Parameters:
REG_W, 5, register-address width.
INSTR_W, 32, instruction width. rs = instr_i[25:21] and rt = instr_i[20:16] for INSTR_W=32; in general rs = [INSTR_W-7 -: REG_W] and rt = [INSTR_W-12 -: REG_W].
LOAD_STALL, 1, bubbles inserted per load-use hazard (1..15).
BRANCH_IN_ID, 1, 1 = detect branch operand hazards in ID; 0 = logic disabled.
ZERO_EXEMPT, 1, 1 = register 0 never causes a hazard.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock, synchronous, active-low
instr_i  in  INSTR_W  instruction in IF/ID
id_uses_rs_i  in  1  ID instruction reads rs
id_uses_rt_i  in  1  ID instruction reads rt
id_branch_i  in  1  ID instruction is a branch compared in ID
branch_taken_i  in  1  branch in ID resolved taken
IDEX_MemRead_i  in  1  ID/EX holds a load
IDEX_RegWrite_i  in  1  ID/EX writes a register
IDEX_RegisterRd_i  in  REG_W  ID/EX destination (post RegDst mux)
EXMEM_MemRead_i  in  1  EX/MEM holds a load
EXMEM_RegisterRd_i  in  REG_W  EX/MEM destination
freeze_i  in  1  external freeze request
PCWrite_o  out  1  1 = PC may update
IFIDWrite_o  out  1  1 = IF/ID may update
MUX8_o  out  1  1 = zero ID/EX control (insert bubble)
IFIDFlush_o  out  1  1 = clear IF/ID (taken branch)
stall_o  out  1  any stall or freeze this cycle
stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- match(r) = (r == src) && use-flag && !(ZERO_EXEMPT && r == 0), where src is rs or rt and the use-flag is the matching id_uses_*_i.
- load_hz = IDEX_MemRead_i && match(IDEX_RegisterRd_i).
- br_hz = BRANCH_IN_ID && id_branch_i && ((IDEX_RegWrite_i && match(IDEX_RegisterRd_i)) || (EXMEM_MemRead_i && match(EXMEM_RegisterRd_i))).
- Detection is combinational from current inputs; outputs are valid in the same cycle, with no one-cycle lag.
- FSM states: IDLE, STALL (remaining-count register rem, 4 bits), FREEZE.
- IDLE:
  - freeze_i -> FREEZE.
  - Else load_hz -> stall this cycle. If LOAD_STALL > 1, go to STALL with rem = LOAD_STALL-1; otherwise stay IDLE.
  - Else br_hz -> stall this cycle and stay IDLE; re-evaluation next cycle re-stalls if the hazard persists.
- STALL: stall every cycle; rem decrements. Leave to IDLE after the cycle in which rem == 1. freeze_i pauses rem and forces freeze outputs, but the state is kept.
- FREEZE: remain while freeze_i = 1; return to IDLE the cycle after it drops.
- Stall outputs: PCWrite_o = 0, IFIDWrite_o = 0, MUX8_o = 1, stall_o = 1.
- Freeze outputs: PCWrite_o = 0, IFIDWrite_o = 0, MUX8_o = 0 (hold, not bubble), stall_o = 1.
- Idle outputs: PCWrite_o = 1, IFIDWrite_o = 1, MUX8_o = 0, stall_o = 0.
- IFIDFlush_o = branch_taken_i && !stall_o. Stall and freeze win over flush; the branch re-resolves once unstalled.
- Priority: freeze > load stall / STALL > branch stall > flush.
- stall_cnt_o increments on every cycle with stall_o = 1 and saturates at all-ones (no wrap).
- Reset (rst_i = 0 at a clock edge):
  - state = IDLE, rem = 0, stall_cnt_o = 0.
  - While rst_i = 0, outputs are forced to PCWrite_o = 1, IFIDWrite_o = 1, MUX8_o = 0, IFIDFlush_o = 0, stall_o = 0.
  - Reset mid-STALL or mid-FREEZE aborts immediately.

Test Plan:
- Load-use, LOAD_STALL=1: IDEX_MemRead_i=1, IDEX_RegisterRd_i=8, instr rs=8 with id_uses_rs_i=1 -> same cycle PCWrite_o=0, MUX8_o=1, stall_o=1; next cycle with the hazard removed, all idle values; stall_cnt_o = 1.
- Zero register and unused operands: IDEX_RegisterRd_i=0 with rs=0 and ZERO_EXEMPT=1 -> no stall. Rt match with id_uses_rt_i=0 -> no stall.
- LOAD_STALL=3: single load-use hazard pulse -> exactly 3 consecutive stall cycles, then IDLE; stall_cnt_o = 3.
- Branch hazards: id_branch_i=1, IDEX_RegWrite_i=1, Rd=5, rs=5 -> stall 1 cycle. EXMEM_MemRead_i=1, Rd=5 -> stall. branch_taken_i=1 during the stall -> IFIDFlush_o=0; after the stall -> IFIDFlush_o=1.
- Freeze mid-STALL with LOAD_STALL=3: freeze_i for 4 cycles starting at the 2nd stall cycle -> MUX8_o=0, PCWrite_o=0 for those 4 cycles, then 2 remaining bubbles resume. Separately, rst_i=0 mid-stall -> idle outputs, stall_cnt_o = 0 next cycle.
- Counter saturation with CNT_W=4: 20 stall cycles -> stall_cnt_o holds 15.

Source files
------------

// File: rtl/hazard_unit_multi.sv
// Load-use / branch-in-ID hazard detector with multi-cycle load penalty,
// external freeze and a saturating stall-cycle counter.
module hazard_unit_multi #(
  parameter int REG_W        = 5,
  parameter int INSTR_W      = 32,
  parameter int LOAD_STALL   = 1,
  parameter int BRANCH_IN_ID = 1,
  parameter int ZERO_EXEMPT  = 1,
  parameter int CNT_W        = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               id_uses_rs_i,
  input  logic               id_uses_rt_i,
  input  logic               id_branch_i,
  input  logic               branch_taken_i,
  input  logic               IDEX_MemRead_i,
  input  logic               IDEX_RegWrite_i,
  input  logic [REG_W-1:0]   IDEX_RegisterRd_i,
  input  logic               EXMEM_MemRead_i,
  input  logic [REG_W-1:0]   EXMEM_RegisterRd_i,
  input  logic               freeze_i,
  output logic               PCWrite_o,
  output logic               IFIDWrite_o,
  output logic               MUX8_o,
  output logic               IFIDFlush_o,
  output logic               stall_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STALL  = 2'd1,
    S_FREEZE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [REG_W-1:0] rs, rt;
  logic             hz_idex, hz_exmem, load_hz, br_hz;
  logic             stall, freeze, any_stall;

  function automatic logic match(input logic [REG_W-1:0] r,
                                 input logic [REG_W-1:0] src,
                                 input logic             use_en);
    match = (r == src) && use_en &&
            !((ZERO_EXEMPT != 0) && (r == {REG_W{1'b0}}));
  endfunction

  assign rs = instr_i[INSTR_W-7 -: REG_W];
  assign rt = instr_i[INSTR_W-12 -: REG_W];

  assign hz_idex  = match(IDEX_RegisterRd_i, rs, id_uses_rs_i) ||
                    match(IDEX_RegisterRd_i, rt, id_uses_rt_i);
  assign hz_exmem = match(EXMEM_RegisterRd_i, rs, id_uses_rs_i) ||
                    match(EXMEM_RegisterRd_i, rt, id_uses_rt_i);
  assign load_hz  = IDEX_MemRead_i && hz_idex;
  assign br_hz    = (BRANCH_IN_ID != 0) && id_branch_i &&
                    ((IDEX_RegWrite_i && hz_idex) || (EXMEM_MemRead_i && hz_exmem));

  // Next-state and stall/freeze decision; FREEZE with freeze_i low behaves as IDLE.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    freeze  = 1'b0;
    case (state_q)
      S_IDLE, S_FREEZE: begin
        if (freeze_i) begin
          freeze  = 1'b1;
          state_d = S_FREEZE;
        end else if (load_hz) begin
          stall = 1'b1;
          if (LOAD_STALL > 1) begin
            state_d = S_STALL;
            rem_d   = 4'(LOAD_STALL - 1);
          end else begin
            state_d = S_IDLE;
          end
        end else if (br_hz) begin
          stall   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STALL: begin
        if (freeze_i) begin
          freeze = 1'b1;
        end else begin
          stall = 1'b1;
          if (rem_q == 4'd1) begin
            state_d = S_IDLE;
            rem_d   = 4'd0;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        rem_d   = 4'd0;
      end
    endcase
    if (!rst_i) begin
      stall  = 1'b0;
      freeze = 1'b0;
    end else begin
      stall  = stall;
      freeze = freeze;
    end
  end

  assign any_stall   = stall || freeze;
  assign PCWrite_o   = !any_stall;
  assign IFIDWrite_o = !any_stall;
  assign MUX8_o      = stall;
  assign stall_o     = any_stall;
  assign IFIDFlush_o = rst_i && branch_taken_i && !any_stall;
  assign stall_cnt_o = cnt_q;

  // Saturating stall-cycle counter.
  always_comb begin
    cnt_d = cnt_q;
    if (any_stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      rem_q   <= 4'd0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
